// File: rtl/dsp_mac_ctrl_if.sv
// dsp_mac_ctrl_if: bundles the operand stream, result handshake and DSP-slice
// controls of dsp_mac_ctrl.
//   slave  : the controller's view (dsp_mac_ctrl)
//   master : the environment's view (upstream source, downstream sink, DSP slice)
// Parameter CNT_W sets the width of len and must match the controller's CNT_W.
// Handshakes: a transfer happens on a rising clk edge where valid && ready;
// valid must not depend on ready, and payload is held while valid && !ready.
interface dsp_mac_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] len;
  logic [47:0]      c_init;
  logic [29:0]      a_in;
  logic [17:0]      b_in;
  logic             in_valid;
  logic             in_ready;
  logic [47:0]      result;
  logic             result_carry;
  logic             result_valid;
  logic             result_ready;
  logic             busy;
  logic [29:0]      dsp_a;
  logic [17:0]      dsp_b;
  logic [47:0]      dsp_c;
  logic [6:0]       dsp_op_mode;
  logic [3:0]       dsp_alu_mode;
  logic             dsp_cea2;
  logic             dsp_ceb2;
  logic             dsp_cec;
  logic             dsp_cem;
  logic             dsp_cep;
  logic [47:0]      dsp_p;
  logic             dsp_carryout;

  modport slave (
    input  start, len, c_init, a_in, b_in, in_valid, result_ready,
           dsp_p, dsp_carryout,
    output in_ready, result, result_carry, result_valid, busy,
           dsp_a, dsp_b, dsp_c, dsp_op_mode, dsp_alu_mode,
           dsp_cea2, dsp_ceb2, dsp_cec, dsp_cem, dsp_cep
  );

  modport master (
    output start, len, c_init, a_in, b_in, in_valid, result_ready,
           dsp_p, dsp_carryout,
    input  in_ready, result, result_carry, result_valid, busy,
           dsp_a, dsp_b, dsp_c, dsp_op_mode, dsp_alu_mode,
           dsp_cea2, dsp_ceb2, dsp_cec, dsp_cem, dsp_cep
  );
endinterface

// File: rtl/dsp_mac_ctrl.sv
// dsp_mac_ctrl: sequences a DSP slice (A2/B2, C, M, P registers) through a
// multiply-accumulate of len operand pairs onto a seed c_init.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus        : dsp_mac_ctrl_if.slave (operand stream, result, DSP controls)
//   dbg_state  : current FSM state (0 IDLE, 1 ACCUM, 2 DRAIN, 3 DONE)
// Parameters: LAT (operand-to-P latency), OPM_DLY (op_mode lag behind the
// operands), CNT_W (beat counter width).
// Optional macro DSP_MAC_STICKY_CARRY_EN: result_carry becomes the OR of
// dsp_carryout from first op_mode issue to capture instead of the carry
// sampled at capture.
module dsp_mac_ctrl #(
  parameter int LAT     = 3,
  parameter int OPM_DLY = 1,
  parameter int CNT_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  dsp_mac_ctrl_if.slave       bus,
  output logic [1:0]          dbg_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  localparam logic [6:0] OPM_CM   = 7'b0110101; // P = C + M
  localparam logic [6:0] OPM_PM   = 7'b0100101; // P = P + M
  localparam logic [6:0] OPM_HOLD = 7'b0100000; // P = P
  localparam logic [6:0] OPM_PC   = 7'b0110000; // P = C
  localparam int         DW       = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(LAT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;       // beats still to accept
  logic             first;     // next beat is the first one
  logic             issued;    // last control word of the operation has gone out
  logic [DW-1:0]    drain_cnt;
  logic             beat;
  logic             in_ready_c;
  logic [6:0]       word;      // control word issued this cycle
  logic [6:0]       opm_pipe [OPM_DLY+1];
  logic [29:0]      a_r;
  logic [17:0]      b_r;
  logic [47:0]      c_r;
  logic             cea_r, cec_r;
  logic [47:0]      result_r;
  logic             carry_r;
`ifdef DSP_MAC_STICKY_CARRY_EN
  logic             sticky_on;
  logic             sticky_acc;
`endif

  always_comb begin
    state_nxt  = state;
    in_ready_c = 1'b0;
    beat       = 1'b0;
    word       = 7'b0;
    case (state)
      IDLE: if (bus.start) state_nxt = ACCUM;
      ACCUM: begin
        in_ready_c = (cnt != '0);
        beat       = bus.in_valid && (cnt != '0);
        if (beat)                        word = first ? OPM_CM : OPM_PM;
        else if (cnt == '0 && !issued)   word = OPM_PC; // len==0: seed only
        else                             word = OPM_HOLD;
        // One ACCUM cycle after the last word, so DRAIN ends when P is final.
        if (issued) state_nxt = DRAIN;
      end
      DRAIN: begin
        word = OPM_HOLD;
        if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
      end
      DONE: if (bus.result_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      first     <= 1'b0;
      issued    <= 1'b0;
      drain_cnt <= '0;
      a_r       <= '0;
      b_r       <= '0;
      c_r       <= '0;
      cea_r     <= 1'b0;
      cec_r     <= 1'b0;
      result_r  <= '0;
      carry_r   <= 1'b0;
      for (int i = 0; i <= OPM_DLY; i++) opm_pipe[i] <= '0;
`ifdef DSP_MAC_STICKY_CARRY_EN
      sticky_on  <= 1'b0;
      sticky_acc <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      cec_r <= 1'b0;
      cea_r <= beat;
      if (beat) begin
        a_r <= bus.a_in;
        b_r <= bus.b_in;
      end
      opm_pipe[0] <= word;
      for (int i = 1; i <= OPM_DLY; i++) opm_pipe[i] <= opm_pipe[i-1];
`ifdef DSP_MAC_STICKY_CARRY_EN
      if (sticky_on) sticky_acc <= sticky_acc | bus.dsp_carryout;
`endif
      case (state)
        IDLE: if (bus.start) begin
          cnt    <= bus.len;
          first  <= 1'b1;
          issued <= 1'b0;
          c_r    <= bus.c_init;
          cec_r  <= 1'b1;
`ifdef DSP_MAC_STICKY_CARRY_EN
          sticky_on  <= 1'b0;
          sticky_acc <= 1'b0;
`endif
        end
        ACCUM: begin
          drain_cnt <= '0;
          if (beat) begin
            cnt   <= cnt - CNT_W'(1);
            first <= 1'b0;
            if (cnt == CNT_W'(1)) issued <= 1'b1;
          end else if (cnt == '0 && !issued) begin
            issued <= 1'b1;
          end
`ifdef DSP_MAC_STICKY_CARRY_EN
          if (beat || (cnt == '0 && !issued)) sticky_on <= 1'b1;
`endif
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + DW'(1);
          if (drain_cnt == DRAIN_LAST) begin
            result_r <= bus.dsp_p;
`ifdef DSP_MAC_STICKY_CARRY_EN
            carry_r   <= sticky_acc | bus.dsp_carryout;
            sticky_on <= 1'b0;
`else
            carry_r  <= bus.dsp_carryout;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready     = in_ready_c;
  assign bus.busy         = (state != IDLE);
  assign bus.result       = result_r;
  assign bus.result_carry = carry_r;
  assign bus.result_valid = (state == DONE);
  assign bus.dsp_a        = a_r;
  assign bus.dsp_b        = b_r;
  assign bus.dsp_c        = c_r;
  assign bus.dsp_cea2     = cea_r;
  assign bus.dsp_ceb2     = cea_r;
  assign bus.dsp_cec      = cec_r;
  assign bus.dsp_cem      = (state != IDLE);
  assign bus.dsp_cep      = (state != IDLE);
  assign bus.dsp_op_mode  = opm_pipe[OPM_DLY];
  assign bus.dsp_alu_mode = 4'b0000;
  assign dbg_state        = state;
endmodule

// File: tb/tb_dsp_mac_ctrl.sv
// tb_dsp_mac_ctrl: directed bench for dsp_mac_ctrl with a behavioural DSP
// slice (A2/B2, C, M, OPMODE and P registers) behind the controller.
module tb_dsp_mac_ctrl;
  localparam logic [6:0] OPM_CM   = 7'b0110101;
  localparam logic [6:0] OPM_PM   = 7'b0100101;
  localparam logic [6:0] OPM_HOLD = 7'b0100000;
  localparam logic [6:0] OPM_PC   = 7'b0110000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dsp_mac_ctrl_if #(.CNT_W(8)) bus ();
  logic [1:0] dbg_state;

  dsp_mac_ctrl #(.LAT(3), .OPM_DLY(1), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- DSP slice model ----------------
  logic [29:0] a2    = '0;
  logic [17:0] b2    = '0;
  logic [47:0] m_r   = '0;
  logic [47:0] c_q   = '0;
  logic [47:0] p_r   = '0;
  logic        co_r  = 1'b0;
  logic [6:0]  opm_r = '0;
  logic [48:0] z_val, sum;

  always_comb begin
    z_val = '0;
    case (opm_r[6:4])
      3'b010:  z_val = {1'b0, p_r};
      3'b011:  z_val = {1'b0, c_q};
      default: z_val = '0;
    endcase
    sum = z_val + ((opm_r[3:0] == 4'b0101) ? {1'b0, m_r} : 49'd0);
  end

  always @(posedge clk) begin
    if (bus.dsp_cea2) a2 <= bus.dsp_a;
    if (bus.dsp_ceb2) b2 <= bus.dsp_b;
    if (bus.dsp_cec)  c_q <= bus.dsp_c;
    if (bus.dsp_cem)  m_r <= {18'b0, a2} * {30'b0, b2};
    opm_r <= bus.dsp_op_mode;
    if (bus.dsp_cep) {co_r, p_r} <= sum;
  end

  assign bus.dsp_p        = p_r;
  assign bus.dsp_carryout = co_r;

  // ---------------- op_mode / in_ready monitor ----------------
  logic mon_rst = 1'b1;
  int   n_cm, n_pm, n_pc, n_hold_mid;
  logic saw_ready;

  always @(negedge clk) begin
    if (mon_rst) begin
      n_cm = 0; n_pm = 0; n_pc = 0; n_hold_mid = 0; saw_ready = 1'b0;
    end else begin
      if (bus.in_ready) saw_ready = 1'b1;
      case (bus.dsp_op_mode)
        OPM_CM:   n_cm++;
        OPM_PM:   n_pm++;
        OPM_PC:   n_pc++;
        OPM_HOLD: if (n_cm == 1 && n_pm < 2) n_hold_mid++;
        default: ;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  logic [47:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic mon_clear();
    mon_rst = 1'b1;
    @(negedge clk);
    #1 mon_rst = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] n, input logic [47:0] seed);
    bus.start  = 1'b1;
    bus.len    = n;
    bus.c_init = seed;
    @(posedge clk); #1;
    bus.start  = 1'b0;
  endtask

  task automatic send_pair(input logic [29:0] a, input logic [17:0] b);
    bit got;
    got = 1'b0;
    bus.a_in     = a;
    bus.b_in     = b;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = bus.in_ready;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (!got) check("beat_timeout", 64'(got), 64'd1);
  endtask

  task automatic wait_result(input string tag, input logic exp_carry, input int hold,
                             input bit poke_start);
    logic [47:0] exp;
    bit got;
    got = 1'b0;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 48'hDEAD;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = bus.result_valid;
    end
    check({tag, "_valid"}, 64'(got), 64'd1);
    check({tag, "_result"}, 64'(bus.result), 64'(exp));
    check({tag, "_carry"}, 64'(bus.result_carry), 64'(exp_carry));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (poke_start) begin
        bus.start  = ~bus.start;
        bus.len    = 8'd2;
        bus.c_init = 48'h5;
      end
      @(negedge clk);
      check({tag, "_hold_valid"}, 64'(bus.result_valid), 64'd1);
      check({tag, "_hold_result"}, 64'(bus.result), 64'(exp));
      check({tag, "_hold_carry"}, 64'(bus.result_carry), 64'(exp_carry));
    end
    @(posedge clk); #1;
    bus.start        = 1'b0;
    bus.result_ready = 1'b1;
    @(posedge clk); #1;
    bus.result_ready = 1'b0;
    @(negedge clk);
    check({tag, "_after_valid"}, 64'(bus.result_valid), 64'd0);
    check({tag, "_after_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_after_state"}, 64'(dbg_state), 64'd0);
  endtask

  task automatic run_basic(input string tag);
    mon_clear();
    exp_q.push_back(48'd51);
    do_start(8'd3, 48'd4);
    send_pair(30'd7, 18'd3);
    send_pair(30'd4, 18'd4);
    send_pair(30'd2, 18'd5);
    wait_result(tag, 1'b0, 2, 1'b0);
    check({tag, "_n_cm"}, 64'(n_cm), 64'd1);
    check({tag, "_n_pm"}, 64'(n_pm), 64'd2);
    check({tag, "_holds_between"}, 64'(n_hold_mid), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.start = 1'b0; bus.len = '0; bus.c_init = '0;
    bus.a_in = '0; bus.b_in = '0; bus.in_valid = 1'b0; bus.result_ready = 1'b0;

    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_result_valid", 64'(bus.result_valid), 64'd0);
    check("rst_ces", 64'({bus.dsp_cea2, bus.dsp_ceb2, bus.dsp_cec, bus.dsp_cem, bus.dsp_cep}), 64'd0);
    check("rst_op_mode", 64'(bus.dsp_op_mode), 64'd0);
    check("rst_alu_mode", 64'(bus.dsp_alu_mode), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Start handshake details: seed load and CEC pulse
    mon_clear();
    exp_q.push_back(48'd51);
    do_start(8'd3, 48'd4);
    @(negedge clk);
    check("start_cec", 64'(bus.dsp_cec), 64'd1);
    check("start_dsp_c", 64'(bus.dsp_c), 64'd4);
    check("start_state", 64'(dbg_state), 64'd1);
    check("start_cem", 64'(bus.dsp_cem), 64'd1);
    @(negedge clk);
    check("cec_pulse_end", 64'(bus.dsp_cec), 64'd0);
    @(posedge clk); #1;
    send_pair(30'd7, 18'd3);
    send_pair(30'd4, 18'd4);
    send_pair(30'd2, 18'd5);
    wait_result("first", 1'b0, 1, 1'b0);

    // Basic MAC, back-to-back pairs
    run_basic("basic");

    // Bubbles: two idle cycles between pairs
    mon_clear();
    exp_q.push_back(48'd51);
    do_start(8'd3, 48'd4);
    send_pair(30'd7, 18'd3);
    @(negedge clk);
    check("bub_dsp_a", 64'(bus.dsp_a), 64'd7);
    check("bub_dsp_b", 64'(bus.dsp_b), 64'd3);
    check("bub_cea2", 64'(bus.dsp_cea2), 64'd1);
    check("bub_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    check("bub_opm_first", 64'(bus.dsp_op_mode), 64'(OPM_CM));
    check("bub_ce_idle", 64'({bus.dsp_cea2, bus.dsp_ceb2}), 64'd0);
    @(posedge clk); #1;
    send_pair(30'd4, 18'd4);
    repeat (2) @(posedge clk);
    #1;
    send_pair(30'd2, 18'd5);
    wait_result("bubble", 1'b0, 1, 1'b0);
    check("bubble_holds_between", 64'(n_hold_mid), 64'd4);
    check("bubble_n_pm", 64'(n_pm), 64'd2);

    // Empty operation
    mon_clear();
    exp_q.push_back(48'h123);
    do_start(8'd0, 48'h123);
    wait_result("empty", 1'b0, 1, 1'b0);
    check("empty_in_ready_seen", 64'(saw_ready), 64'd0);
    check("empty_n_pc", 64'(n_pc), 64'd1);
    check("empty_n_cm", 64'(n_cm), 64'd0);

    // Backpressure and carry, with ignored start pulses
    mon_clear();
    exp_q.push_back(48'h0);
    do_start(8'd1, 48'hFFFF_FFFF_FFFF);
    send_pair(30'd1, 18'd1);
    wait_result("carry", 1'b1, 5, 1'b1);

    // Reset in the middle of ACCUM
    mon_clear();
    do_start(8'd3, 48'd4);
    send_pair(30'd7, 18'd3);
    send_pair(30'd4, 18'd4);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_state", 64'(dbg_state), 64'd0);
    check("midrst_result_valid", 64'(bus.result_valid), 64'd0);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    run_basic("rerun");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end
endmodule
